// File: rtl/alu_sequencer_if.sv
// Bundle of the command, ALU and response signals exchanged with the ALU sequencer.
// The slave modport is the sequencer's view; master is the view of the environment driving it.
interface alu_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_rs1;
    logic [1:0] cmd_rs2;
    logic [3:0] cmd_imm;
    logic       cmd_use_carry;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_sel;
    logic       alu_cin;
    logic [3:0] alu_out;
    logic       alu_cout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_use_carry,
        input  alu_out, alu_cout, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, alu_cin,
        output rsp_valid, rsp_data, rsp_carry, rsp_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_use_carry,
        output alu_out, alu_cout, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, alu_cin,
        input  rsp_valid, rsp_data, rsp_carry, rsp_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Single-issue sequencer: reads a 4x4 register file, drives an external ALU for one
// cycle, writes the result back and holds a response until it is accepted.
module alu_sequencer (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_LOADI = 4'b1110;

    state_t     state_r;
    state_t     state_s;
    logic [3:0] reg_file_r [4];
    logic       carry_r;
    logic [1:0] rd_r;
    logic [3:0] op_r;
    logic [3:0] imm_r;
    logic [3:0] alu_a_r;
    logic [3:0] alu_b_r;
    logic [3:0] alu_sel_r;
    logic       alu_cin_r;
    logic       rsp_valid_r;
    logic [3:0] rsp_data_r;
    logic       rsp_carry_r;
    logic       rsp_err_r;

    logic       accept_s;
    logic       err_s;
    logic       wr_en_s;
    logic       carry_wr_s;
    logic [3:0] wr_data_s;
    logic       carry_next_s;

    assign accept_s      = (state_r == IDLE) && bus.cmd_valid;
    assign bus.cmd_ready = (state_r == IDLE);
    assign bus.alu_a     = alu_a_r;
    assign bus.alu_b     = alu_b_r;
    assign bus.alu_sel   = alu_sel_r;
    assign bus.alu_cin   = alu_cin_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_carry = rsp_carry_r;
    assign bus.rsp_err   = rsp_err_r;

    // Next-state logic for the IDLE -> ISSUE -> RESP handshake sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: state_s = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Writeback decode for the latched opcode; unlisted codes are rejected.
    always_comb begin
        err_s      = 1'b0;
        wr_en_s    = 1'b0;
        carry_wr_s = 1'b0;
        wr_data_s  = bus.alu_out;
        case (op_r)
            OP_ADD, OP_SUB: begin
                wr_en_s    = 1'b1;
                carry_wr_s = 1'b1;
            end
            OP_DIV: begin
                if (alu_b_r == 4'd0) begin
                    err_s = 1'b1;
                end else begin
                    wr_en_s = 1'b1;
                end
            end
            4'b0010, 4'b0100, 4'b0101, 4'b1000, 4'b1001,
            4'b1010, 4'b1011, 4'b1100, 4'b1101: begin
                wr_en_s = 1'b1;
            end
            OP_LOADI: begin
                wr_en_s   = 1'b1;
                wr_data_s = imm_r;
            end
            default: begin
                err_s = 1'b1;
            end
        endcase
        if (carry_wr_s) begin
            carry_next_s = bus.alu_cout;
        end else begin
            carry_next_s = carry_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture on accept, writeback and response capture on ISSUE exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                reg_file_r[i] <= 4'd0;
            end
            carry_r     <= 1'b0;
            rd_r        <= 2'd0;
            op_r        <= 4'd0;
            imm_r       <= 4'd0;
            alu_a_r     <= 4'd0;
            alu_b_r     <= 4'd0;
            alu_sel_r   <= 4'd0;
            alu_cin_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 4'd0;
            rsp_carry_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                alu_a_r   <= reg_file_r[bus.cmd_rs1];
                alu_b_r   <= reg_file_r[bus.cmd_rs2];
                alu_sel_r <= bus.cmd_op;
                alu_cin_r <= bus.cmd_use_carry & carry_r;
                rd_r      <= bus.cmd_rd;
                op_r      <= bus.cmd_op;
                imm_r     <= bus.cmd_imm;
            end else begin
                alu_cin_r <= alu_cin_r;
            end

            if (state_r == ISSUE) begin
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= err_s;
                rsp_carry_r <= carry_next_s;
                carry_r     <= carry_next_s;
                if (wr_en_s) begin
                    reg_file_r[rd_r] <= wr_data_s;
                    rsp_data_r       <= wr_data_s;
                end else begin
                    rsp_data_r <= 4'd0;
                end
            end else if ((state_r == RESP) && bus.rsp_ready) begin
                rsp_valid_r <= 1'b0;
            end else begin
                rsp_valid_r <= rsp_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed test of alu_sequencer against a behavioural external ALU; every
// comparison is an immediate assertion with hand-computed expectations.
module tb_alu_sequencer;

    logic clk;
    logic rst_n;
    logic [4:0] alu_t;
    int n_asserts;
    int n_fail;

    alu_sequencer_if bus ();

    alu_sequencer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 0 add, 1 sub (cout = borrow), 2 mul, 3 div, 4 and, 5 or, 8 xor.
    always_comb begin
        alu_t        = 5'd0;
        bus.alu_out  = 4'd0;
        bus.alu_cout = 1'b0;
        case (bus.alu_sel)
            4'b0000: begin
                alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'd0, bus.alu_cin};
                bus.alu_out  = alu_t[3:0];
                bus.alu_cout = alu_t[4];
            end
            4'b0001: begin
                alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {4'd0, bus.alu_cin};
                bus.alu_out  = alu_t[3:0];
                bus.alu_cout = alu_t[4];
            end
            4'b0010: bus.alu_out = bus.alu_a * bus.alu_b;
            4'b0011: begin
                if (bus.alu_b != 4'd0) bus.alu_out = bus.alu_a / bus.alu_b;
                else bus.alu_out = 4'd0;
            end
            4'b0100: bus.alu_out = bus.alu_a & bus.alu_b;
            4'b0101: bus.alu_out = bus.alu_a | bus.alu_b;
            4'b1000: bus.alu_out = bus.alu_a ^ bus.alu_b;
            default: bus.alu_out = 4'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete command: accept, fixed-latency response check, handshake.
    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2, input logic [3:0] imm,
                           input logic uc, input logic exp_cin, input logic [3:0] exp_data,
                           input logic exp_carry, input logic exp_err);
        @(negedge clk);
        bus.cmd_op        = op;
        bus.cmd_rd        = rd;
        bus.cmd_rs1       = rs1;
        bus.cmd_rs2       = rs2;
        bus.cmd_imm       = imm;
        bus.cmd_use_carry = uc;
        bus.cmd_valid     = 1'b1;
        chk({tag, ".cmd_ready"}, bus.cmd_ready, 8'd1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".valid_issue"}, bus.rsp_valid, 8'd0);
        chk({tag, ".alu_sel"}, bus.alu_sel, {4'd0, op});
        chk({tag, ".alu_cin"}, bus.alu_cin, {7'd0, exp_cin});
        @(negedge clk);
        chk({tag, ".valid_resp"}, bus.rsp_valid, 8'd1);
        chk({tag, ".data"}, bus.rsp_data, {4'd0, exp_data});
        chk({tag, ".carry"}, bus.rsp_carry, {7'd0, exp_carry});
        chk({tag, ".err"}, bus.rsp_err, {7'd0, exp_err});
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
    endtask

    initial begin
        n_asserts         = 0;
        n_fail            = 0;
        rst_n             = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_op        = 4'd0;
        bus.cmd_rd        = 2'd0;
        bus.cmd_rs1       = 2'd0;
        bus.cmd_rs2       = 2'd0;
        bus.cmd_imm       = 4'd0;
        bus.cmd_use_carry = 1'b0;
        bus.rsp_ready     = 1'b0;

        #12;
        chk("rst.cmd_ready", bus.cmd_ready, 8'd1);
        chk("rst.rsp_valid", bus.rsp_valid, 8'd0);
        chk("rst.alu_a", bus.alu_a, 8'd0);
        chk("rst.alu_b", bus.alu_b, 8'd0);
        chk("rst.alu_sel", bus.alu_sel, 8'd0);
        chk("rst.alu_cin", bus.alu_cin, 8'd0);
        chk("rst.rsp_data", bus.rsp_data, 8'd0);
        chk("rst.rsp_carry", bus.rsp_carry, 8'd0);
        chk("rst.rsp_err", bus.rsp_err, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //        tag        op       rd    rs1   rs2   imm    uc    cin   data   carry err
        run_cmd("loadi_r1", 4'b1110, 2'd1, 2'd0, 2'd0, 4'd9, 1'b0, 1'b0, 4'd9,  1'b0, 1'b0);
        run_cmd("loadi_r2", 4'b1110, 2'd2, 2'd0, 2'd0, 4'd8, 1'b0, 1'b0, 4'd8,  1'b0, 1'b0);
        run_cmd("add_r3",   4'b0000, 2'd3, 2'd1, 2'd2, 4'd0, 1'b0, 1'b0, 4'd1,  1'b1, 1'b0);
        run_cmd("addc_r0",  4'b0000, 2'd0, 2'd1, 2'd2, 4'd0, 1'b1, 1'b1, 4'd2,  1'b1, 1'b0);
        run_cmd("loadi_r0", 4'b1110, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0);
        run_cmd("div0_r3",  4'b0011, 2'd3, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1);
        run_cmd("or_r3",    4'b0101, 2'd3, 2'd3, 2'd3, 4'd0, 1'b0, 1'b0, 4'd1,  1'b1, 1'b0);
        run_cmd("op0111",   4'b0111, 2'd1, 2'd2, 2'd2, 4'd0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b1);
        run_cmd("op1111",   4'b1111, 2'd1, 2'd2, 2'd2, 4'd3, 1'b1, 1'b1, 4'd0,  1'b1, 1'b1);
        run_cmd("or_r1",    4'b0101, 2'd1, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0, 4'd9,  1'b1, 1'b0);
        run_cmd("add_self", 4'b0000, 2'd1, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0, 4'd2,  1'b1, 1'b0);
        run_cmd("sub_r0",   4'b0001, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0, 1'b0, 4'd6,  1'b0, 1'b0);
        run_cmd("mul_r3",   4'b0010, 2'd3, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 4'd4,  1'b0, 1'b0);

        // Backpressure: OR R2=R1|R2 = 2|8 = 10, next command held valid meanwhile.
        @(negedge clk);
        bus.cmd_op = 4'b0101; bus.cmd_rd = 2'd2; bus.cmd_rs1 = 2'd1; bus.cmd_rs2 = 2'd2;
        bus.cmd_use_carry = 1'b0;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_op = 4'b1110; bus.cmd_rd = 2'd3; bus.cmd_imm = 4'd5;
        @(negedge clk);
        chk("bp.ready_issue", bus.cmd_ready, 8'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.valid", bus.rsp_valid, 8'd1);
            chk("bp.data", bus.rsp_data, 8'd10);
            chk("bp.cmd_ready", bus.cmd_ready, 8'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp.ready_after", bus.cmd_ready, 8'd1);
        chk("bp.valid_after", bus.rsp_valid, 8'd0);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("bp2.valid_issue", bus.rsp_valid, 8'd0);
        @(negedge clk);
        chk("bp2.valid", bus.rsp_valid, 8'd1);
        chk("bp2.data", bus.rsp_data, 8'd5);
        chk("bp2.carry", bus.rsp_carry, 8'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;

        // Reset in the middle of ISSUE abandons the command.
        @(negedge clk);
        bus.cmd_op = 4'b0000; bus.cmd_rd = 2'd2; bus.cmd_rs1 = 2'd1; bus.cmd_rs2 = 2'd3;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.valid", bus.rsp_valid, 8'd0);
        chk("mrst.ready", bus.cmd_ready, 8'd1);
        chk("mrst.alu_a", bus.alu_a, 8'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst.valid_post", bus.rsp_valid, 8'd0);
        chk("mrst.ready_post", bus.cmd_ready, 8'd1);
        run_cmd("rd_r0", 4'b0101, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        run_cmd("rd_r1", 4'b0101, 2'd1, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        run_cmd("rd_r2", 4'b0101, 2'd2, 2'd2, 2'd2, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        run_cmd("rd_r3", 4'b0101, 2'd3, 2'd3, 2'd3, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
